tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Central tick scheduler for the display and game logic.
- Replaces raw divider-bit clocks with single-cycle enable strobes on the one master clock (100 MHz).
- Display strobes (pixel, 7-segment scan) always run. Game and blink strobes are gated by a run/pause/single-step state machine that the game FSM drives through a req/ack handshake.

Parameters:
- CNT_W, 26: width of every channel counter.
- PIX_DIV, 4: pixel strobe period in clk cycles (25 MHz).
- SEG_DIV, 262144: 7-segment scan strobe period (~381 Hz).
- GAME_DIV, 8388608: game-update strobe period (~12 Hz).
- BLINK_DIV, 33554432: blink strobe period (~3 Hz).
- Each DIV must satisfy 2 <= DIV <= 2^CNT_W; violations are a compile-time error.

Ports:
- clk  in  1  master clock, 100 MHz.
- clr_n  in  1  asynchronous active-low reset.
- run_en  in  1  level; 1 = game running, 0 = paused.
- step_req  in  1  level request for one game tick while paused.
- step_ack  out  1  handshake acknowledge for step_req.
- pix_tick  out  1  one-cycle pixel enable.
- seg_tick  out  1  one-cycle segment-scan enable.
- seg_sel  out  2  anode scan index, 0..3.
- game_tick  out  1  one-cycle game-update enable.
- blink_tick  out  1  one-cycle blink enable.
- blink_level  out  1  square wave; toggles on each blink_tick.
- state  out  2  0=PAUSE, 1=RUN, 2=STEP, 3=ACK.

Behaviour:
- Reset (clr_n=0, async):
  - All counters = 0; all *_tick = 0; seg_sel = 0; blink_level = 0; step_ack = 0; state = PAUSE.
- Channel rule (identical for all four channels):
  - Counter cnt advances only when the channel is enabled.
  - If enabled and cnt == DIV-1: next cnt = 0 and tick is registered high for exactly one cycle. Otherwise tick = 0.
  - First tick after reset release appears in the cycle following the DIV-th rising edge. Period is exactly DIV cycles.
- Enable sources:
  - pix and seg channels: always enabled.
  - game and blink channels: enabled only in RUN. In PAUSE and ACK they hold their counter value (freeze, no clear).
- seg_sel: increments mod 4 (3 -> 0) on each seg_tick edge, i.e. in the same cycle seg_tick is high.
- blink_level: toggles in the cycle blink_tick is high.
- FSM transitions:
  - PAUSE: run_en=1 -> RUN (run_en has priority over step_req). Else step_req=1 -> STEP. Else stay.
  - RUN: run_en=0 -> PAUSE; game/blink counters freeze at their current value.
  - STEP: lasts exactly one cycle. game_tick is registered high and the game counter is cleared to 0; the blink channel is not advanced. Always -> ACK.
  - ACK: step_ack=1. When step_req=0 -> PAUSE with step_ack=0. run_en is ignored in STEP/ACK.
- Exactly one game_tick per handshake, regardless of how long step_req stays high.
- Simultaneous events: a RUN->PAUSE transition in the same cycle as a game counter wrap still emits that game_tick (the wrap is evaluated with the current state = RUN).
- Reset mid-handshake: returns to PAUSE with step_ack=0. The requester must re-issue step_req.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: TICK_SYNC_EN.
- Defined: run_en and step_req each pass through a 2-flop synchronizer, reset to 0 by clr_n. All FSM reaction latencies increase by 2 cycles.
- Undefined: inputs are used directly and must be synchronous to clk.

Test Plan (sim params: PIX_DIV=4, SEG_DIV=8, GAME_DIV=16, BLINK_DIV=32, TICK_SYNC_EN undefined):
- Reset release, run_en=0 for 100 cycles:
  - pix_tick every 4 cycles, first after edge 4.
  - seg_tick every 8; seg_sel sequence 1,2,3,0,1...
  - game_tick, blink_tick stay 0; state=0.
- run_en=1 at cycle 0:
  - state=1 after 1 edge.
  - game_tick period 16; blink_tick period 32; blink_level toggles every 32 cycles.
- In RUN, drop run_en when game cnt=10, hold 50 cycles, reassert:
  - No game_tick while paused.
  - Next game_tick occurs 6 counted cycles after resume (counter froze at 10).
- In PAUSE, raise step_req and hold 20 cycles:
  - state 0->2->3.
  - Exactly one game_tick (during STEP); step_ack=1 until step_req drops, then state=0.
- step_req=1 and run_en=1 in same PAUSE cycle:
  - state -> RUN; no STEP; step_ack stays 0.
- Assert clr_n=0 while state=ACK:
  - All outputs return to reset values immediately (asynchronously); state=0 after release.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// Run/pause/single-step control handshake between the game FSM (master)
// and the tick scheduler (slave).
interface tick_scheduler_if;
  logic       run_en;
  logic       step_req;
  logic       step_ack;
  logic [1:0] state;

  modport master (output run_en, output step_req, input step_ack, input state);
  modport slave  (input run_en, input step_req, output step_ack, output state);
endinterface

// File: rtl/tick_scheduler.sv
// Single-clock enable-strobe generator: free-running pixel/scan strobes plus
// game/blink strobes gated by a run/pause/step FSM. Define TICK_SYNC_EN to synchronize run_en/step_req.
module tick_scheduler #(
  parameter int CNT_W     = 26,
  parameter int PIX_DIV   = 4,
  parameter int SEG_DIV   = 262144,
  parameter int GAME_DIV  = 8388608,
  parameter int BLINK_DIV = 33554432
) (
  input  logic             clk,
  input  logic             clr_n,
  tick_scheduler_if.slave  ctrl,
  output logic             pix_tick,
  output logic             seg_tick,
  output logic [1:0]       seg_sel,
  output logic             game_tick,
  output logic             blink_tick,
  output logic             blink_level
);

  localparam longint MAX_DIV = longint'(1) << CNT_W;

  if (PIX_DIV < 2 || longint'(PIX_DIV) > MAX_DIV) begin : g_bad_pix
    $error("PIX_DIV out of range");
  end
  if (SEG_DIV < 2 || longint'(SEG_DIV) > MAX_DIV) begin : g_bad_seg
    $error("SEG_DIV out of range");
  end
  if (GAME_DIV < 2 || longint'(GAME_DIV) > MAX_DIV) begin : g_bad_game
    $error("GAME_DIV out of range");
  end
  if (BLINK_DIV < 2 || longint'(BLINK_DIV) > MAX_DIV) begin : g_bad_blink
    $error("BLINK_DIV out of range");
  end

  localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] SEG_LAST   = CNT_W'(SEG_DIV - 1);
  localparam logic [CNT_W-1:0] GAME_LAST  = CNT_W'(GAME_DIV - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             run_in, step_in;
  logic [CNT_W-1:0] pix_cnt, seg_cnt, game_cnt, blink_cnt;

`ifdef TICK_SYNC_EN
  logic [1:0] run_sync, step_sync;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      run_sync  <= 2'b00;
      step_sync <= 2'b00;
    end else begin
      run_sync  <= {run_sync[0], ctrl.run_en};
      step_sync <= {step_sync[0], ctrl.step_req};
    end
  end

  assign run_in  = run_sync[1];
  assign step_in = step_sync[1];
`else
  assign run_in  = ctrl.run_en;
  assign step_in = ctrl.step_req;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= PAUSE;
    else        state_q <= state_d;
  end

  // run_en wins over step_req from PAUSE; STEP/ACK ignore run_en entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PAUSE: begin
        if (run_in)       state_d = RUN;
        else if (step_in) state_d = STEP;
      end
      RUN:     if (!run_in) state_d = PAUSE;
      STEP:    state_d = ACK;
      ACK:     if (!step_in) state_d = PAUSE;
      default: state_d = PAUSE;
    endcase
  end

  assign ctrl.state    = state_q;
  assign ctrl.step_ack = (state_q == ACK);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pix_cnt  <= '0;
      pix_tick <= 1'b0;
    end else if (pix_cnt == PIX_LAST) begin
      pix_cnt  <= '0;
      pix_tick <= 1'b1;
    end else begin
      pix_cnt  <= pix_cnt + CNT_W'(1);
      pix_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      seg_cnt  <= '0;
      seg_tick <= 1'b0;
      seg_sel  <= 2'd0;
    end else if (seg_cnt == SEG_LAST) begin
      seg_cnt  <= '0;
      seg_tick <= 1'b1;
      seg_sel  <= seg_sel + 2'd1;
    end else begin
      seg_cnt  <= seg_cnt + CNT_W'(1);
      seg_tick <= 1'b0;
    end
  end

  // STEP forces one game strobe and restarts the game period from zero.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      game_cnt  <= '0;
      game_tick <= 1'b0;
    end else if (state_q == STEP) begin
      game_cnt  <= '0;
      game_tick <= 1'b1;
    end else if (state_q == RUN && game_cnt == GAME_LAST) begin
      game_cnt  <= '0;
      game_tick <= 1'b1;
    end else begin
      if (state_q == RUN) game_cnt <= game_cnt + CNT_W'(1);
      game_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      blink_cnt   <= '0;
      blink_tick  <= 1'b0;
      blink_level <= 1'b0;
    end else if (state_q == RUN && blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_tick  <= 1'b1;
      blink_level <= ~blink_level;
    end else begin
      if (state_q == RUN) blink_cnt <= blink_cnt + CNT_W'(1);
      blink_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: arithmetic reference model compared every cycle,
// directed handshake/pause scenarios, then randomized run_en/step_req traffic.
module tb_tick_scheduler;

  localparam int CNT_W     = 26;
  localparam int PIX_DIV   = 4;
  localparam int SEG_DIV   = 8;
  localparam int GAME_DIV  = 16;
  localparam int BLINK_DIV = 32;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       pix_tick, seg_tick, game_tick, blink_tick, blink_level;
  logic [1:0] seg_sel;

  tick_scheduler_if ctrl ();

  tick_scheduler #(
    .CNT_W(CNT_W), .PIX_DIV(PIX_DIV), .SEG_DIV(SEG_DIV),
    .GAME_DIV(GAME_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .ctrl(ctrl),
    .pix_tick(pix_tick),
    .seg_tick(seg_tick),
    .seg_sel(seg_sel),
    .game_tick(game_tick),
    .blink_tick(blink_tick),
    .blink_level(blink_level)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic run, input logic step);
    ctrl.run_en   = run;
    ctrl.step_req = step;
  endtask

  // Reference model: k = edges since reset; game/blink progress counted as RUN edges.
  int k = 0, game_runs = 0, blink_runs = 0, mode = 0;
  int exp_pix = 0, exp_seg = 0, exp_sel = 0, exp_game = 0, exp_blink = 0, exp_level = 0;

  initial forever begin
    @(posedge clk or negedge clr_n);
    if (!clr_n) begin
      k = 0; game_runs = 0; blink_runs = 0; mode = 0;
      exp_pix = 0; exp_seg = 0; exp_sel = 0; exp_game = 0; exp_blink = 0; exp_level = 0;
    end else begin
      k++;
      exp_pix   = (k % PIX_DIV == 0) ? 1 : 0;
      exp_seg   = (k % SEG_DIV == 0) ? 1 : 0;
      exp_sel   = (k / SEG_DIV) % 4;
      exp_game  = 0;
      exp_blink = 0;
      if (mode == 1) begin
        game_runs++;
        blink_runs++;
        exp_game  = (game_runs % GAME_DIV == 0) ? 1 : 0;
        exp_blink = (blink_runs % BLINK_DIV == 0) ? 1 : 0;
      end else if (mode == 2) begin
        game_runs = 0;
        exp_game  = 1;
      end
      exp_level = (blink_runs / BLINK_DIV) % 2;
      case (mode)
        0:       mode = ctrl.run_en ? 1 : (ctrl.step_req ? 2 : 0);
        1:       mode = ctrl.run_en ? 1 : 0;
        2:       mode = 3;
        default: mode = ctrl.step_req ? 3 : 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (clr_n && check_en) begin
      checkOutput("pix_tick", int'(pix_tick), exp_pix);
      checkOutput("seg_tick", int'(seg_tick), exp_seg);
      checkOutput("seg_sel", int'(seg_sel), exp_sel);
      checkOutput("game_tick", int'(game_tick), exp_game);
      checkOutput("blink_tick", int'(blink_tick), exp_blink);
      checkOutput("blink_level", int'(blink_level), exp_level);
      checkOutput("state", int'(ctrl.state), mode);
      checkOutput("step_ack", int'(ctrl.step_ack), (mode == 3) ? 1 : 0);
    end
  end

  int n_pix, n_seg, n_game, n_blink, first_at;
  logic r_rand, s_rand;

  initial begin
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    check_en = 1'b1;

    // Paused free-run: only display strobes.
    n_pix = 0; n_seg = 0; n_game = 0; n_blink = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      n_pix += int'(pix_tick); n_seg += int'(seg_tick);
      n_game += int'(game_tick); n_blink += int'(blink_tick);
      if (i == 3)  checkOutput("pix_before_edge4", int'(pix_tick), 0);
      if (i == 4)  checkOutput("pix_at_edge4", int'(pix_tick), 1);
      if (i == 8)  checkOutput("seg_sel_first", int'(seg_sel), 1);
      if (i == 16) checkOutput("seg_sel_second", int'(seg_sel), 2);
      if (i == 32) checkOutput("seg_sel_wrap", int'(seg_sel), 0);
    end
    checkOutput("pix_count_100", n_pix, 25);
    checkOutput("seg_count_100", n_seg, 12);
    checkOutput("game_count_paused", n_game, 0);
    checkOutput("blink_count_paused", n_blink, 0);
    checkOutput("state_paused", int'(ctrl.state), 0);

    // Run, pause with game counter at 10, resume.
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("state_run", int'(ctrl.state), 1);
    repeat (9) @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    n_game = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      n_game += int'(game_tick);
    end
    checkOutput("game_while_paused", n_game, 0);
    checkOutput("state_after_drop", int'(ctrl.state), 0);
    applyStimulus(1'b1, 1'b0);
    first_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (game_tick && first_at == 0) first_at = i;
      if (first_at != 0) break;
    end
    checkOutput("resume_game_latency", first_at, 7);
    n_game = 0; n_blink = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      n_game += int'(game_tick); n_blink += int'(blink_tick);
    end
    checkOutput("game_count_64", n_game, 4);
    checkOutput("blink_count_64", n_blink, 2);

    // Single-step handshake with a long request.
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ctrl.state == 2'd0) break;
    end
    checkOutput("state_pause_before_step", int'(ctrl.state), 0);
    applyStimulus(1'b0, 1'b1);
    n_game = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_game += int'(game_tick);
      if (i == 1) checkOutput("state_step", int'(ctrl.state), 2);
      if (i == 2) checkOutput("state_ack", int'(ctrl.state), 3);
      if (i == 2) checkOutput("game_after_step", int'(game_tick), 1);
    end
    checkOutput("game_per_handshake", n_game, 1);
    checkOutput("step_ack_held", int'(ctrl.step_ack), 1);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("state_after_release", int'(ctrl.state), 0);
    checkOutput("step_ack_released", int'(ctrl.step_ack), 0);

    // run_en and step_req together from PAUSE: run wins.
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    checkOutput("state_run_priority", int'(ctrl.state), 1);
    checkOutput("ack_run_priority", int'(ctrl.step_ack), 0);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("state_back_pause", int'(ctrl.state), 0);

    // Asynchronous reset while in ACK.
    applyStimulus(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("state_ack_pre_reset", int'(ctrl.state), 3);
    #2 clr_n = 1'b0;
    #1;
    checkOutput("rst_state", int'(ctrl.state), 0);
    checkOutput("rst_step_ack", int'(ctrl.step_ack), 0);
    checkOutput("rst_ticks", int'({pix_tick, seg_tick, game_tick, blink_tick}), 0);
    checkOutput("rst_seg_sel", int'(seg_sel), 0);
    checkOutput("rst_blink_level", int'(blink_level), 0);
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    checkOutput("state_after_reset", int'(ctrl.state), 0);

    // Randomized control traffic against the model.
    r_rand = 1'b0; s_rand = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) r_rand = ~r_rand;
      if ($urandom_range(0, 5) == 0)  s_rand = ~s_rand;
      applyStimulus(r_rand, s_rand);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
